// File: rtl/ins_sequencer.sv
// Instruction sequencer: issues a loaded program buffer one word per cycle to a
// CPU ins port, inserting a single bubble on a read-after-write register hazard.
module ins_sequencer #(
    parameter int ins_width = 18,
    parameter int depth     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_en,
    input  logic [$clog2(depth)-1:0]     load_addr,
    input  logic [ins_width-1:0]         load_data,
    input  logic                         start,
    input  logic [$clog2(depth):0]       length,
    input  logic                         abort,
    output logic [ins_width-1:0]         ins,
    output logic                         ins_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int aw = $clog2(depth);
    localparam int pw = aw + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [pw-1:0]        pc_q, pc_d;
    logic [pw-1:0]        len_q, len_d;
    logic [ins_width-1:0] ins_q, ins_d;
    logic                 ins_valid_q, ins_valid_d;
    logic                 done_q, done_d;
    logic                 wr_en;

    logic [ins_width-1:0] prog_mem [depth];

    logic [ins_width-1:0] next_word;
    logic                 shift_op;
    logic                 hazard;
    logic                 start_ok;

    assign next_word = prog_mem[pc_q[aw-1:0]];
    // Opcodes 110/111 carry a shift amount in the rs2 slot, not a register.
    assign shift_op  = (next_word[17:16] == 2'b11);
    assign hazard    = ins_valid_q &&
                       ((ins_q[14:10] == next_word[9:5]) ||
                        (!shift_op && (ins_q[14:10] == next_word[4:0])));
    assign start_ok  = start && (length != '0) && (length <= pw'(depth));

    // NOTE: program storage has no reset so it maps onto plain RAM and keeps
    // its contents across rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            prog_mem[load_addr] <= load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block latch-free.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN: begin
                if (abort)              state_d = IDLE;
                else if (pc_q == len_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        len_d       = len_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        done_d      = done_q;
        wr_en       = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en = load_en;
                if (start_ok) begin
                    len_d       = length;
                    ins_d       = prog_mem[0];
                    ins_valid_d = 1'b1;
                    pc_d        = pw'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    ins_valid_d = 1'b0;
                    done_d      = 1'b0;
                    pc_d        = '0;
                end else if (pc_q == len_q) begin
                    ins_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else if (hazard) begin
                    ins_valid_d = 1'b0;
                end else begin
                    ins_d       = next_word;
                    ins_valid_d = 1'b1;
                    pc_d        = pc_q + 1'b1;
                end
            end
            DONE: begin
                done_d      = 1'b0;
                ins_valid_d = 1'b0;
                if (abort) pc_d = '0;
            end
            default: begin
                ins_valid_d = 1'b0;
                done_d      = 1'b0;
                pc_d        = '0;
            end
        endcase
    end

    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_ins_sequencer.sv
// Directed self-checking bench for ins_sequencer: normal issue, hazard bubbles,
// shift-opcode exemption, illegal lengths, abort, and asynchronous reset.
module tb_ins_sequencer;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [17:0] load_data;
    logic        start;
    logic [4:0]  length;
    logic        abort;
    logic [17:0] ins;
    logic        ins_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [17:0] w [16];

    ins_sequencer #(.ins_width(18), .depth(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .length    (length),
        .abort     (abort),
        .ins       (ins),
        .ins_valid (ins_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [17:0] e_ins, input logic e_v,
                              input logic e_busy, input logic e_done);
        check({tag, ".ins"},       32'(ins),       32'(e_ins));
        check({tag, ".ins_valid"}, 32'(ins_valid), 32'(e_v));
        check({tag, ".busy"},      32'(busy),      32'(e_busy));
        check({tag, ".done"},      32'(done),      32'(e_done));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [17:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    initial begin
        logic [17:0] b0, b1;
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; length = '0; abort = 1'b0;
        step();
        step();
        expect_out("reset", 18'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Three independent words issue back to back.
        w[0] = mk(3'b000, 5'd1, 5'd4, 5'd5);
        w[1] = mk(3'b000, 5'd2, 5'd6, 5'd7);
        w[2] = mk(3'b000, 5'd3, 5'd8, 5'd9);
        for (int i = 0; i < 3; i++) load(4'(i), w[i]);
        expect_out("s1.after_load", 18'h0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; length = 5'd3;
        step();
        start = 1'b0;
        expect_out("s1.c1", w[0], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s1.c2", w[1], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s1.c3", w[2], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s1.done", w[2], 1'b0, 1'b1, 1'b1);
        step(); expect_out("s1.idle", w[2], 1'b0, 1'b0, 1'b0);

        // rs1 hazard on rd=0 forces one bubble.
        b0 = 18'b000_00000_00010_00001;
        b1 = 18'b100_00011_00000_00001;
        load(4'd0, b0); load(4'd1, b1);
        start = 1'b1; length = 5'd2;
        step();
        start = 1'b0;
        expect_out("s2.c1", b0, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s2.bubble", b0, 1'b0, 1'b1, 1'b0);
        step(); expect_out("s2.c3", b1, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s2.done", b1, 1'b0, 1'b1, 1'b1);
        step(); expect_out("s2.idle", b1, 1'b0, 1'b0, 1'b0);

        // Shift opcode: rs2 equal to previous rd is not a hazard.
        b0 = mk(3'b000, 5'd5, 5'd1, 5'd2);
        b1 = 18'b110_00100_00011_00101;
        load(4'd0, b0); load(4'd1, b1);
        start = 1'b1; length = 5'd2;
        step();
        start = 1'b0;
        expect_out("s3.c1", b0, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s3.c2", b1, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s3.done", b1, 1'b0, 1'b1, 1'b1);
        step(); expect_out("s3.idle", b1, 1'b0, 1'b0, 1'b0);

        // Same rs2 match with a non-shift opcode does stall.
        b1 = mk(3'b010, 5'd4, 5'd3, 5'd5);
        load(4'd1, b1);
        start = 1'b1; length = 5'd2;
        step();
        start = 1'b0;
        expect_out("s3b.c1", b0, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s3b.bubble", b0, 1'b0, 1'b1, 1'b0);
        step(); expect_out("s3b.c3", b1, 1'b1, 1'b1, 1'b0);
        step(); expect_out("s3b.done", b1, 1'b0, 1'b1, 1'b1);
        step(); expect_out("s3b.idle", b1, 1'b0, 1'b0, 1'b0);

        // Illegal lengths are ignored.
        start = 1'b1; length = 5'd0;
        step(); expect_out("s4.len0", b1, 1'b0, 1'b0, 1'b0);
        length = 5'd17;
        step(); expect_out("s4.len17", b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step(); expect_out("s4.after", b1, 1'b0, 1'b0, 1'b0);

        // Full-depth run, loads and start ignored while running, abort on cycle 5.
        for (int i = 0; i < 16; i++) begin
            w[i] = mk(3'b001, 5'(i), 5'd20, 5'd21);
            load(4'(i), w[i]);
        end
        start = 1'b1; length = 5'd16;
        step();
        expect_out("s5.c1", w[0], 1'b1, 1'b1, 1'b0);
        length = 5'd1;
        load_en = 1'b1; load_addr = 4'd0; load_data = 18'h3FFFF;
        step();
        start = 1'b0; load_en = 1'b0;
        expect_out("s5.c2", w[1], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s5.c3", w[2], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s5.c4", w[3], 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_out("s5.abort", w[3], 1'b0, 1'b0, 1'b0);
        step(); expect_out("s5.no_done", w[3], 1'b0, 1'b0, 1'b0);
        start = 1'b1; length = 5'd1;
        step();
        start = 1'b0;
        expect_out("s5.len1", w[0], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s5.len1_done", w[0], 1'b0, 1'b1, 1'b1);
        step(); expect_out("s5.len1_idle", w[0], 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run; buffer must survive.
        start = 1'b1; length = 5'd16;
        step();
        start = 1'b0;
        expect_out("s6.c1", w[0], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s6.c2", w[1], 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_out("s6.async", 18'h0, 1'b0, 1'b0, 1'b0);
        step(); expect_out("s6.held", 18'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(); expect_out("s6.released", 18'h0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; length = 5'd2;
        step();
        start = 1'b0;
        expect_out("s6.rerun1", w[0], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s6.rerun2", w[1], 1'b1, 1'b1, 1'b0);
        step(); expect_out("s6.rerun_done", w[1], 1'b0, 1'b1, 1'b1);
        step(); expect_out("s6.rerun_idle", w[1], 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
